// File: rtl/rom_burst_reader.sv
// Parametrised ROM with a burst read engine: one {addr, len} request streams
// len+1 consecutive words (wrapping at DEPTH) through a backpressure-aware output register.
module rom_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] INIT =
        {32'h0C0D0E0F, 32'h08090A0B, 32'h04050607, 32'h00010203}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_err
);

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  remaining;
        logic                  err;
    } burst_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state_q, state_d;
    burst_t                burst_q;
    logic                  accept;
    logic                  load;
    logic                  beat_last;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [DATA_WIDTH-1:0] rom_word;

    assign accept    = req_valid && req_ready;
    assign beat_last = (burst_q.remaining == '0) || burst_q.err;
    // Wrap at DEPTH, which need not be a power of two.
    assign next_addr = (burst_q.addr == LAST_ADDR) ? '0 : burst_q.addr + ADDR_WIDTH'(1);

    always_comb begin
        rom_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (burst_q.addr == ADDR_WIDTH'(i))
                rom_word = INIT[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if (load && beat_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The output slot is free, or being drained this cycle; rd_ready never reaches rd_valid combinationally.
    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        load      = (state_q == BURST) && (!rd_valid || rd_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            if (accept) begin
                burst_q.addr      <= req_addr;
                burst_q.remaining <= req_len;
                burst_q.err       <= ({1'b0, req_addr} >= DEPTH_EXT);
            end else if (load) begin
                burst_q.addr      <= next_addr;
                burst_q.remaining <= burst_q.remaining - LEN_WIDTH'(1);
            end

            if (load) begin
                rd_valid <= 1'b1;
                rd_data  <= burst_q.err ? '0 : rom_word;
                rd_last  <= beat_last;
                rd_err   <= burst_q.err;
            end else if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Directed bench for rom_burst_reader: a default DEPTH=4 build plus a DEPTH=3
// build that exercises out-of-range requests.
module tb_rom_burst_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_valid3 = 1'b0;
    logic [1:0]  req_addr = '0;
    logic [3:0]  req_len = '0;
    logic        rd_ready = 1'b0;

    logic        req_ready, rd_valid, rd_last, rd_err;
    logic [31:0] rd_data;
    logic        req_ready3, rd_valid3, rd_last3, rd_err3;
    logic [31:0] rd_data3;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] w4 [4] = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};

    always #5 clk = ~clk;

    rom_burst_reader dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_len(req_len),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err)
    );

    rom_burst_reader #(
        .DEPTH(3),
        .INIT({32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0})
    ) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_addr(req_addr), .req_len(req_len),
        .rd_valid(rd_valid3), .rd_ready(rd_ready),
        .rd_data(rd_data3), .rd_last(rd_last3), .rd_err(rd_err3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [31:0] d, input logic last);
        chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
        chk({tag, "_data"},  64'(rd_data),  64'(d));
        chk({tag, "_last"},  64'(rd_last),  64'(last));
        chk({tag, "_err"},   64'(rd_err),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0]  pat;
        logic [31:0] held;
        logic        held_v;
        int          idx;

        // reset state
        tick(); tick();
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_data",  64'(rd_data),  64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 64'(req_ready), 64'd1);

        // single beat
        rd_ready = 1'b1; req_valid = 1'b1; req_addr = 2'd2; req_len = 4'd0;
        tick(); req_valid = 1'b0;
        chk("single_lat", 64'(rd_valid), 64'd0);
        chk("single_busy", 64'(req_ready), 64'd0);
        tick();
        beat("single", 32'h08090A0B, 1'b1);
        chk("single_rdy", 64'(req_ready), 64'd1);
        tick();
        chk("single_done", 64'(rd_valid), 64'd0);

        // wrap burst from addr 3
        req_valid = 1'b1; req_addr = 2'd3; req_len = 4'd5;
        tick(); req_valid = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            beat("wrap", w4[(3 + i) % 4], i == 5);
            tick();
        end
        chk("wrap_end", 64'(rd_valid), 64'd0);

        // backpressure: rd_ready pattern 1,0,0,1,0,1,1 then held high
        req_valid = 1'b1; req_addr = 2'd0; req_len = 4'd3;
        tick(); req_valid = 1'b0;
        pat = 7'b1101001; idx = 0; held_v = 1'b0; held = '0;
        for (int c = 0; c < 12; c++) begin
            rd_ready = (c < 7) ? pat[c] : 1'b1;
            if (rd_valid && held_v) chk("bp_stable", 64'(rd_data), 64'(held));
            if (rd_valid && rd_ready) begin
                chk("bp_data", 64'(rd_data), 64'(w4[idx % 4]));
                chk("bp_last", 64'(rd_last), 64'(idx == 3));
                idx++;
                held_v = 1'b0;
            end else if (rd_valid) begin
                held_v = 1'b1;
                held = rd_data;
            end
            tick();
        end
        chk("bp_count", 64'(idx), 64'd4);

        // out-of-range on the DEPTH=3 build
        rd_ready = 1'b1; req_valid3 = 1'b1; req_addr = 2'd3; req_len = 4'd7;
        tick(); req_valid3 = 1'b0;
        chk("oob_lat", 64'(rd_valid3), 64'd0);
        tick();
        chk("oob_valid", 64'(rd_valid3), 64'd1);
        chk("oob_data",  64'(rd_data3),  64'd0);
        chk("oob_err",   64'(rd_err3),   64'd1);
        chk("oob_last",  64'(rd_last3),  64'd1);
        tick();
        chk("oob_once",  64'(rd_valid3), 64'd0);
        chk("oob_rdy",   64'(req_ready3), 64'd1);
        req_valid3 = 1'b1; req_addr = 2'd2; req_len = 4'd1;
        tick(); req_valid3 = 1'b0;
        tick();
        chk("d3_w2",   64'(rd_data3), 64'hA2A2A2A2);
        chk("d3_w2l",  64'(rd_last3), 64'd0);
        chk("d3_w2e",  64'(rd_err3),  64'd0);
        tick();
        chk("d3_w0",   64'(rd_data3), 64'hA0A0A0A0);
        chk("d3_w0l",  64'(rd_last3), 64'd1);
        tick();
        chk("d3_end",  64'(rd_valid3), 64'd0);

        // reset mid-burst
        req_valid = 1'b1; req_addr = 2'd0; req_len = 4'd15;
        tick(); req_valid = 1'b0;
        tick(); beat("mid1", w4[0], 1'b0);
        tick(); beat("mid2", w4[1], 1'b0);
        tick(); beat("mid3", w4[2], 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("mid_post_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_quiet", 64'(rd_valid), 64'd0);
        end
        req_valid = 1'b1; req_addr = 2'd1; req_len = 4'd0;
        tick(); req_valid = 1'b0;
        tick(); beat("mid_new", 32'h04050607, 1'b1);
        tick();

        // back-to-back with req_valid held high; the second request changes under req_ready=0
        req_valid = 1'b1; req_addr = 2'd0; req_len = 4'd1;
        tick();
        req_addr = 2'd2; req_len = 4'd1;
        chk("b2b_lat", 64'(rd_valid), 64'd0);
        tick(); beat("b2b_a0", w4[0], 1'b0);
        tick(); beat("b2b_a1", w4[1], 1'b1);
        chk("b2b_rdy", 64'(req_ready), 64'd1);
        tick(); req_valid = 1'b0;
        chk("b2b_gap", 64'(rd_valid), 64'd0);
        tick(); beat("b2b_b0", w4[2], 1'b0);
        tick(); beat("b2b_b1", w4[3], 1'b1);
        tick();
        chk("b2b_end", 64'(rd_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
Parametrised read-only memory with a burst read engine and valid/ready handshakes on both the request and data sides. It replaces the fixed single-access, rd_en-gated ROM tables. A client issues {start address, length}. The block streams the words at consecutive addresses, wrapping modulo DEPTH, and tolerates downstream backpressure. It serves as a coefficient, microcode or boot-table source feeding streaming datapaths.

Parameters:
DATA_WIDTH, 32, width of each ROM word
DEPTH, 4, number of ROM words; need not be a power of two (>=2)
ADDR_WIDTH, $clog2(DEPTH), width of req_addr
LEN_WIDTH, 4, width of req_len; burst = req_len+1 beats (1..2^LEN_WIDTH)
INIT, {32'h0C0D0E0F,32'h08090A0B,32'h04050607,32'h00010203}, packed DEPTH*DATA_WIDTH contents; word i = INIT[i*DATA_WIDTH +: DATA_WIDTH]

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  burst request valid
req_ready  output  1  block can accept a request
req_addr  input  ADDR_WIDTH  start word address
req_len  input  LEN_WIDTH  beats minus one
rd_valid  output  1  rd_data/rd_last/rd_err valid
rd_ready  input  1  consumer accepts beat
rd_data  output  DATA_WIDTH  ROM word
rd_last  output  1  final beat of burst
rd_err  output  1  beat belongs to an out-of-range request

Behaviour:
- Reset (clk edge with rst=1) forces:
  - state=IDLE, rd_valid=0, rd_data=0, rd_last=0, rd_err=0.
  - Internal address and beat counters cleared.
  - req_ready=0 while rst=1.
- A reset mid-burst aborts the burst. Undelivered beats are discarded and no rd_last is produced.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready: latch addr, remaining=req_len, err=(req_addr>=DEPTH), go to BURST.
  - BURST: req_ready=0.
- Output register: loads when state==BURST && (!rd_valid || rd_ready), i.e. a slot is free or being freed this cycle. On load:
  - rd_data=ROM[addr], or 0 if err.
  - rd_valid=1, rd_err=err.
  - rd_last=(remaining==0) || err.
- Address advance: addr = (addr==DEPTH-1) ? 0 : addr+1, so wrap is at DEPTH, not 2^ADDR_WIDTH. Then remaining decrements.
- When the loaded beat has rd_last=1, state returns to IDLE on the same edge.
- Out-of-range request (req_addr>=DEPTH): exactly one beat, rd_data=0, rd_err=1, rd_last=1, regardless of req_len.
- If the output register is not loaded and rd_valid&&rd_ready, rd_valid clears. rd_data, rd_last and rd_err then hold their values; downstream logic must not sample them while rd_valid=0.
- While rd_valid=1 && rd_ready=0, rd_data/rd_last/rd_err are stable.
- Latency:
  - Request accepted on edge k; first beat visible (rd_valid=1) after edge k+1.
  - With rd_ready held 1, one beat per cycle, no bubbles.
  - Back-to-back: a new request can be accepted on the edge after the last beat is loaded. The first beat of the second burst appears one cycle after the last beat of the first, i.e. one idle cycle between bursts.
- Burst length exceeding DEPTH wraps repeatedly, e.g. DEPTH=4, len=9 yields words 0,1,2,3,0,1,2,3,0,1.
- req_addr/req_len are sampled only on accept. Changes while req_ready=0 are ignored.
- No combinational path from rd_ready to rd_valid or rd_data. rd_ready gates only the register enable and the req path.

Test Plan:
- Single beat: reset, req addr=2 len=0, rd_ready=1. rd_valid for exactly 1 cycle, two edges after accept, with rd_data=32'h08090A0B, rd_last=1, rd_err=0. req_ready returns to 1.
- Wrap burst: addr=3 len=5, rd_ready=1. Data 0C0D0E0F,00010203,04050607,08090A0B,0C0D0E0F,00010203 on 6 consecutive cycles. rd_last only on the 6th beat.
- Backpressure: addr=0 len=3, rd_ready toggling 1,0,0,1,0,1,1. Each word 00010203..0C0D0E0F is delivered exactly once, in order. rd_data is stable while stalled.
- Out-of-range: DEPTH=3 build (INIT of 3 words), addr=3 len=7. Exactly one beat with rd_data=0, rd_err=1, rd_last=1. Next request addr=2 len=1 returns word2 then word0.
- Reset mid-burst: addr=0 len=15; assert rst for 1 cycle after the 3rd beat. rd_valid=0 and req_ready=0 during rst. After rst, req_ready=1 and no further beats appear. A new request addr=1 len=0 returns 04050607.
- Back-to-back: two requests (addr=0 len=1; addr=2 len=1) with req_valid held high. Beats 00010203, 04050607(last), then one gap cycle, then 08090A0B, 0C0D0E0F(last).
